// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and strobe decode for the memory access sequencer.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  // Request captured on acceptance; drives the memory buses for the whole cycle.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Memory strobes for a given state, returned as {csel_n, wr_en_n}.
  // Write enable is only asserted in ACCESS, so it falls with chip select
  // and releases one cycle before chip select (which is still low in HOLD).
  function automatic logic [1:0] strobes(input state_e st, input logic we);
    logic [1:0] s;
    s = 2'b11;
    case (st)
      ST_ACCESS: s = {1'b0, ~we};
      ST_HOLD:   s = 2'b01;
      default:   s = 2'b11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Sequences one CPU read/write into a timed async-memory cycle: setup, CS low for ACC_CYCLES, hold, recover.
// Latency: request accepted on edge 0, oACK and read data in cycle ACC_CYCLES+2, idle again at ACC_CYCLES+4.
// Backpressure: none queued; iREQ is only sampled while oBUSY=0, requests seen while busy are dropped.
//
// Ports:
//   iCLK, iRSTn                : clock, asynchronous active-low reset
//   iREQ, iWE, iADDR, iWDATA   : single-cycle request, sampled in IDLE only
//   oBUSY, oACK, oRDATA        : busy flag, one-cycle completion pulse, registered read data
//   oM_ADDR, oM_DATA           : memory address / data-in buses (held for the whole transaction)
//   oM_CSELn, oM_WR_ENn        : registered active-low chip select / write enable
//   iM_DATA                    : memory data-out bus
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ACC_CYCLES = 4
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iREQ,
  input  logic              iWE,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [WORD_W-1:0] iWDATA,
  output logic              oBUSY,
  output logic              oACK,
  output logic [WORD_W-1:0] oRDATA,
  output logic [ADDR_W-1:0] oM_ADDR,
  output logic [WORD_W-1:0] oM_DATA,
  output logic              oM_CSELn,
  output logic              oM_WR_ENn,
  input  logic [WORD_W-1:0] iM_DATA
);

  localparam int              CNT_W    = $clog2(ACC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACC_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              csel_n_q, csel_n_d;
  logic              wr_en_n_q, wr_en_n_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (iREQ) begin
          state_d = ST_SETUP;
          req_d   = '{we: iWE, addr: iADDR, wdata: iWDATA};
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Saturating increment: the counter tops out at ACC_CYCLES and never wraps.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          // Memory access time has elapsed by the end of the last ACCESS cycle.
          if (!req_q.we) begin
            rdata_d = iM_DATA;
          end
        end
      end
      ST_HOLD:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every output is a flop
    // that is valid in the same cycle as the state it belongs to.
    {csel_n_d, wr_en_n_d} = strobes(state_d, req_d.we);
    ack_d                 = (state_d == ST_HOLD);
    busy_d                = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      csel_n_q  <= 1'b1;
      wr_en_n_q <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      csel_n_q  <= csel_n_d;
      wr_en_n_q <= wr_en_n_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign oBUSY     = busy_q;
  assign oACK      = ack_q;
  assign oRDATA    = rdata_q;
  assign oM_ADDR   = req_q.addr;
  assign oM_DATA   = req_q.wdata;
  assign oM_CSELn  = csel_n_q;
  assign oM_WR_ENn = wr_en_n_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: 350-unit async memory model, per-transaction timeline reference, random traffic.
// Latency: each transaction is checked cycle by cycle over ACC+4 cycles.
// Backpressure: request-input noise is injected while busy and must be ignored.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ACC = 4;
  localparam int T   = ACC + 4;

  logic        iCLK   = 1'b0;
  logic        iRSTn  = 1'b0;
  logic        iREQ   = 1'b0;
  logic        iWE    = 1'b0;
  logic [11:0] iADDR  = '0;
  logic [11:0] iWDATA = '0;
  logic [11:0] iM_DATA;
  logic        oBUSY, oACK, oM_CSELn, oM_WR_ENn;
  logic [11:0] oRDATA, oM_ADDR, oM_DATA;

  int n_checks = 0;
  int n_errors = 0;

  mem_ctrl #(.ACC_CYCLES(ACC)) dut (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iREQ     (iREQ),
    .iWE      (iWE),
    .iADDR    (iADDR),
    .iWDATA   (iWDATA),
    .oBUSY    (oBUSY),
    .oACK     (oACK),
    .oRDATA   (oRDATA),
    .oM_ADDR  (oM_ADDR),
    .oM_DATA  (oM_DATA),
    .oM_CSELn (oM_CSELn),
    .oM_WR_ENn(oM_WR_ENn),
    .iM_DATA  (iM_DATA)
  );

  always #50 iCLK = ~iCLK;

  // ---------------- asynchronous memory model ----------------
  logic [11:0] mem [4096];
  logic [11:0] m_rd;
  int          mem_gen = 0;
  assign iM_DATA = m_rd;

  // Output is garbage until 350 units after chip select falls.
  initial begin
    m_rd = '0;
    forever begin
      int g;
      @(negedge oM_CSELn);
      g    = mem_gen;
      m_rd = 12'($urandom);
      #350;
      if (g == mem_gen && !oM_CSELn) m_rd = mem[oM_ADDR];
    end
  end

  always @(posedge oM_CSELn) mem_gen++;

  // Write commits on the rising edge of write enable while selected.
  always @(posedge oM_WR_ENn) if (oM_CSELn === 1'b0) mem[oM_ADDR] = oM_DATA;

  // ---------------- reference model ----------------
  logic [11:0] ref_mem [4096];
  logic [11:0] ref_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_busy", tag),  32'(oBUSY),     32'd0);
    check($sformatf("%s_ack", tag),   32'(oACK),      32'd0);
    check($sformatf("%s_rdata", tag), 32'(oRDATA),    32'd0);
    check($sformatf("%s_maddr", tag), 32'(oM_ADDR),   32'd0);
    check($sformatf("%s_mdata", tag), 32'(oM_DATA),   32'd0);
    check($sformatf("%s_cs", tag),    32'(oM_CSELn),  32'd1);
    check($sformatf("%s_we", tag),    32'(oM_WR_ENn), 32'd1);
  endtask

  // Called anywhere inside an IDLE cycle (away from the edge); returns #1 into
  // the IDLE cycle after RECOVER, so a following call runs back-to-back.
  // noise: 0 quiet, 1 random request-input churn while busy, 2 iREQ pulse in cycle 3.
  // abort_at: cycle in which reset is asserted (0 = never).
  task automatic run_txn(input logic we, input logic [11:0] addr, input logic [11:0] wdata,
                         input int noise, input int abort_at, input string tag);
    logic [T:1]  cs_v, we_v, ack_v, busy_v, cs_e, we_e, ack_e, busy_e;
    int          addr_bad, data_bad;
    logic [11:0] rd_hold, rd_end, exp_rd;
    addr_bad = 0;
    data_bad = 0;
    rd_hold  = '0;
    rd_end   = '0;
    for (int k = 1; k <= T; k++) begin
      cs_e[k]   = !(k >= 2 && k <= ACC + 2);
      we_e[k]   = !(we && k >= 2 && k <= ACC + 1);
      ack_e[k]  = (k == ACC + 2);
      busy_e[k] = (k <= ACC + 3);
    end
    iREQ = 1'b1; iWE = we; iADDR = addr; iWDATA = wdata;
    @(posedge iCLK);
    for (int k = 1; k <= T; k++) begin
      #1;
      cs_v[k]   = oM_CSELn;
      we_v[k]   = oM_WR_ENn;
      ack_v[k]  = oACK;
      busy_v[k] = oBUSY;
      if (k <= ACC + 3 && oM_ADDR !== addr) addr_bad++;
      if (k <= ACC + 3 && we && oM_DATA !== wdata) data_bad++;
      if (k == ACC + 2) rd_hold = oRDATA;
      if (k == T) rd_end = oRDATA;
      if (k == abort_at) begin
        #20;
        iRSTn = 1'b0;
        iREQ  = 1'b0;
        #1;
        check_reset($sformatf("%s_async", tag));
        ref_rdata = '0;
        @(posedge iCLK);
        #1;
        check_reset($sformatf("%s_held", tag));
        return;
      end
      if (k >= ACC + 3) begin
        iREQ = 1'b0;
      end else if (noise == 1) begin
        iREQ   = 1'($urandom_range(0, 1));
        iWE    = 1'($urandom_range(0, 1));
        iADDR  = 12'($urandom);
        iWDATA = 12'($urandom);
      end else if (noise == 2) begin
        iREQ = (k == 3);
      end else begin
        iREQ = 1'b0;
      end
      if (k < T) @(posedge iCLK);
    end
    if (we) ref_mem[addr] = wdata;
    else    ref_rdata     = ref_mem[addr];
    exp_rd = ref_rdata;
    check($sformatf("%s_cs", tag),       32'(cs_v),   32'(cs_e));
    check($sformatf("%s_we", tag),       32'(we_v),   32'(we_e));
    check($sformatf("%s_ack", tag),      32'(ack_v),  32'(ack_e));
    check($sformatf("%s_busy", tag),     32'(busy_v), 32'(busy_e));
    check($sformatf("%s_addr_bad", tag), 32'(addr_bad), 32'd0);
    check($sformatf("%s_data_bad", tag), 32'(data_bad), 32'd0);
    check($sformatf("%s_rd_hold", tag),  32'(rd_hold),  32'(exp_rd));
    check($sformatf("%s_rd_end", tag),   32'(rd_end),   32'(exp_rd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    ref_rdata = '0;

    // Reset state
    repeat (3) @(posedge iCLK);
    #1;
    check_reset("por");
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(posedge iCLK);
    #1;
    check("idle_busy", 32'(oBUSY), 32'd0);

    // Write then read, with request inputs churning during the write
    run_txn(1'b1, 12'h123, 12'hA5C, 1, 0, "wr123");
    run_txn(1'b0, 12'h123, 12'h000, 2, 0, "rd123");
    check("rd123_lit", 32'(oRDATA), 32'h0A5C);
    run_txn(1'b1, 12'h010, 12'h777, 0, 0, "wr010");

    // Back-to-back at the address extremes
    run_txn(1'b1, 12'h000, 12'h5A3, 0, 0, "b2b_w000");
    run_txn(1'b0, 12'h000, 12'h000, 0, 0, "b2b_r000");
    run_txn(1'b1, 12'hFFF, 12'hC3F, 0, 0, "b2b_wfff");
    run_txn(1'b0, 12'hFFF, 12'h000, 0, 0, "b2b_rfff");
    check("b2b_fff_lit", 32'(oRDATA), 32'h0C3F);

    // Random traffic, biased to a small window so reads hit earlier writes
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [11:0] addr;
      int          gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge iCLK);
      if (gap != 0) #1;
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 1) == 1) ? 12'(12'h020 + $urandom_range(0, 7)) : 12'($urandom);
      if (addr == 12'h010) addr = 12'h011;
      run_txn(we, addr, 12'($urandom), 1, 0, $sformatf("rnd%0d", n));
    end

    // Reset in cycle 3 of a write, then a read released together with reset
    run_txn(1'b1, 12'h2AB, 12'h3C3, 0, 3, "rstwr");
    @(negedge iCLK);
    iRSTn = 1'b1;
    run_txn(1'b0, 12'h010, 12'h000, 0, 0, "rd010");
    check("rd010_lit", 32'(oRDATA), 32'h0777);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Synchronous access sequencer that sits directly upstream of the 12-bit, 4K-word asynchronous memory unit. It converts a single-cycle CPU request (read or write) into a correctly timed memory cycle: address setup, active-low chip select held for the memory access time, write-enable pulse, hold, and recovery. Read data is registered back to the requester, and completion is signalled with a one-cycle acknowledge.

## Interface
- ACC_CYCLES, default 4: clock cycles for which chip select is held low. Must be ≥1. ACC_CYCLES × Tclk must be ≥ the memory access time (350 ns); the default gives 400 ns at 10 MHz.
- iCLK  in  1  system clock; all state changes on its rising edge.
- iRSTn  in  1  reset; asynchronous, active-low.
- iREQ  in  1  request, sampled only in IDLE.
- iWE  in  1  1 = write, 0 = read; sampled with iREQ.
- iADDR  in  12  word address; sampled with iREQ.
- iWDATA  in  12  write data; sampled with iREQ.
- oBUSY  out  1  high in every state except IDLE.
- oACK  out  1  one-cycle completion pulse.
- oRDATA  out  12  registered read data; holds its value until the next read completes.
- oM_ADDR  out  12  to memory address bus.
- oM_DATA  out  12  to memory data-in bus.
- oM_CSELn  out  1  memory chip select, active-low.
- oM_WR_ENn  out  1  memory write enable, active-low.
- iM_DATA  in  12  from memory data-out bus.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on iREQ=1.
  - SETUP → ACCESS unconditionally.
  - ACCESS → HOLD when the counter reaches ACC_CYCLES−1.
  - HOLD → RECOVER unconditionally.
  - RECOVER → IDLE unconditionally.
- On acceptance in IDLE: latch iWE, iADDR and iWDATA into internal registers. oM_ADDR and oM_DATA are driven from these registers for the whole transaction, so later changes on the request inputs are ignored.
- Strobe values per state, as (oM_CSELn, oM_WR_ENn):
  - IDLE (1,1)
  - SETUP (1,1)
  - ACCESS (0, ~we)
  - HOLD (0,1)
  - RECOVER (1,1)
- Write enable therefore falls together with chip select and rises one cycle before chip select. Address and data stay stable throughout.
- Read: on the clock edge leaving the last ACCESS cycle, oRDATA ← iM_DATA.
- oACK = 1 for exactly the HOLD cycle, for both reads and writes.
- Back-to-back requests: if iREQ=1 in the IDLE cycle following RECOVER, a new transaction starts. Requests presented while oBUSY=1 are ignored, not queued. The requester must hold iREQ until it sees oBUSY=1, or simply pulse iREQ while oBUSY=0.
- Access counter: width $clog2(ACC_CYCLES+1). Cleared in SETUP, increments in ACCESS, never wraps.
- All memory-side outputs are registered, so strobes are glitch-free.

## Timing
- Cycle numbering: acceptance edge = cycle 0.
  - SETUP occupies cycle 1.
  - ACCESS occupies cycles 2 … ACC_CYCLES+1.
  - HOLD (oACK=1, read data valid on oRDATA) is cycle ACC_CYCLES+2.
  - RECOVER is cycle ACC_CYCLES+3.
  - IDLE again at cycle ACC_CYCLES+4.
- Throughput: one transaction per ACC_CYCLES+4 cycles.
- Reset value of every output while iRSTn=0:
  - oBUSY=0, oACK=0
  - oRDATA=0, oM_ADDR=0, oM_DATA=0
  - oM_CSELn=1, oM_WR_ENn=1
  - FSM in IDLE, counter=0
- Reset asserted mid-transaction: strobes are released immediately (asynchronously), and no oACK is issued. After a write interrupted this way, the contents of that address are undefined. The first request after reset release is accepted normally.
- iREQ together with iRSTn deassertion in the same cycle: the request is sampled on the first rising edge at which iRSTn=1.

## Structure
- Shared header const.h holds: word width (12), address width (12), and the state encodings IDLE/SETUP/ACCESS/HOLD/RECOVER as 3-bit localparams.
- No sub-module is needed. The counter and FSM are implemented inline in a single mem_ctrl module.
- Top-level integration connects oM_* to the memory unit's iADDR/iDATA/iCSELn/iWR_ENn and its oDATA to iM_DATA.

## Test plan
All scenarios use ACC_CYCLES=4 and a 100 ns clock against the 350 ns memory model.
- Write then read: write 0xA5C to address 0x123, then read 0x123. Required response: oRDATA=0xA5C in the read's HOLD cycle (cycle 6), and oACK pulses once per transaction.
- Strobe ordering: check oM_WR_ENn low only within oM_CSELn low, rising one cycle before oM_CSELn, and oM_ADDR stable from SETUP through RECOVER. Changing iADDR mid-transaction has no effect.
- Back-to-back: hold iREQ=1 with alternating write/read to 0x000 and 0xFFF. Required response: new transactions start every 8 cycles and data round-trips correctly at both address extremes.
- Busy drop: pulse iREQ during cycle 3 of an active read. Required response: ignored, exactly one oACK, no extra memory cycle.
- Reset mid-write: assert iRSTn=0 in cycle 3 of a write. Required response: oM_CSELn=1 and oM_WR_ENn=1 immediately, all outputs at their reset values, and a following read of another address (e.g. 0x010, written earlier with 0x777) still returns 0x777.
